// File: rtl/ecall_service_unit_pkg.sv
// ecall_service_unit_pkg
// Shared constants for the ECALL service unit: the SYSTEM opcode that carries ECALL,
// the service numbers decoded from a7, and the 3-bit FSM state encoding.
package ecall_service_unit_pkg;

  // RISC-V SYSTEM opcode; ECALL is this opcode with funct3 == 0.
  localparam logic [6:0] ECALL = 7'b1110011;

  localparam int unsigned SVC_PRINT_INT = 1;
  localparam int unsigned SVC_READ_INT  = 5;
  localparam int unsigned SVC_EXIT      = 10;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StOut  = 3'd1,
    StIn   = 3'd2,
    StWb   = 3'd3,
    StRel  = 3'd4,
    StHalt = 3'd5
  } state_e;

endpackage

// File: rtl/ecall_service_unit_finish_confirm.sv
// ecall_service_unit_finish_confirm
// Synchronises the asynchronous operator "finish" input and confirms it once it has been
// seen high for CONFIRM_CYCLES consecutive synchronised cycles, but only after it was first
// seen low (armed). This forces a release-and-press and filters short glitches.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   finish      raw asynchronous operator input
//   clr         clears armed flag and counter (held while no confirm is being awaited)
//   finish_s    synchronised finish
//   confirm     press confirmed (level, valid while count is at its limit)
module ecall_service_unit_finish_confirm #(
  parameter int unsigned CONFIRM_CYCLES = 3,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic finish,
  input  logic clr,
  output logic finish_s,
  output logic confirm
);

  localparam int unsigned CntW = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CONFIRM_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   armed_q, armed_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  assign finish_s = sync_q[SYNC_STAGES-1];
  assign confirm  = armed_q && (cnt_q == CntMax);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], finish};

    armed_d = armed_q;
    if (clr) begin
      armed_d = 1'b0;
    end else if (!finish_s) begin
      armed_d = 1'b1;
    end

    // Saturating count of consecutive high cycles, counted only once armed.
    cnt_d = cnt_q;
    if (clr || !finish_s) begin
      cnt_d = '0;
    end else if (armed_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ecall_service_unit.sv
// ecall_service_unit
// ECALL handler between decode and board I/O. On an ECALL in IDLE it latches the service
// number (a7) and argument (a0), stalls the core and runs print / read / exit. Print and
// read wait for a debounced operator confirm on "finish"; read writes the captured switch
// value back to a0 with a one-cycle strobe. Unknown services pulse svc_err. Exit halts.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_vld, opcode, funct3       decoded instruction (ECALL detection)
//   a7, a0                          service number and argument registers
//   finish                          asynchronous operator confirm
//   in_data                         switch value for the read service
//   stall                           hold PC and pipeline
//   out_vld, out_data               display value for the print service
//   in_req                          waiting for operator input
//   wb_en, wb_data                  one-cycle a0 write-back
//   halted                          sticky after exit
//   svc_err                         one-cycle pulse on unknown service
module ecall_service_unit
  import ecall_service_unit_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SVC_W          = 8,
  parameter int unsigned CONFIRM_CYCLES = 3,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_vld,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] a7,
  input  logic [DATA_W-1:0] a0,
  input  logic              finish,
  input  logic [DATA_W-1:0] in_data,
  output logic              stall,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              in_req,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic              svc_err
);

  state_e            state_q, state_d;
  logic [SVC_W-1:0]  svc_q, svc_d;
  logic [DATA_W-1:0] arg_q, arg_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              err_q, err_d;

  logic             trig;
  logic [SVC_W-1:0] svc_sel;
  logic             is_print, is_read, is_exit;
  logic             finish_s, confirm, fc_clr;

  // Only the low SVC_W bits of a7 select the service.
  logic unused_a7;
  assign unused_a7 = ^a7[DATA_W-1:SVC_W];

  assign svc_sel  = a7[SVC_W-1:0];
  assign trig     = (state_q == StIdle) && instr_vld && (opcode == ECALL) && (funct3 == 3'd0);
  assign is_print = (svc_sel == SVC_W'(SVC_PRINT_INT));
  assign is_read  = (svc_sel == SVC_W'(SVC_READ_INT));
  assign is_exit  = (svc_sel == SVC_W'(SVC_EXIT));

  // Held clear outside OUT/IN, so every entry into a waiting state starts disarmed.
  assign fc_clr = (state_q != StOut) && (state_q != StIn);

  ecall_service_unit_finish_confirm #(
    .CONFIRM_CYCLES (CONFIRM_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_finish_confirm (
    .clk      (clk),
    .rst_n    (rst_n),
    .finish   (finish),
    .clr      (fc_clr),
    .finish_s (finish_s),
    .confirm  (confirm)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          if (is_print) begin
            state_d = StOut;
          end else if (is_read) begin
            state_d = StIn;
          end else if (is_exit) begin
            state_d = StHalt;
          end else begin
            state_d = StRel;
          end
        end
      end
      StOut:  if (confirm) state_d = StRel;
      StIn:   if (confirm) state_d = StWb;
      StWb:   state_d = StRel;
      StRel:  if (!finish_s) state_d = StIdle;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Capture registers: service/argument on trigger, switch value on read confirm.
  always_comb begin
    svc_d = svc_q;
    arg_d = arg_q;
    in_d  = in_q;
    err_d = trig && !is_print && !is_read && !is_exit;
    if (trig) begin
      svc_d = svc_sel;
      arg_d = a0;
    end
    if ((state_q == StIn) && confirm) begin
      in_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      svc_q <= '0;
      arg_q <= '0;
      in_q  <= '0;
      err_q <= 1'b0;
    end else begin
      svc_q <= svc_d;
      arg_q <= arg_d;
      in_q  <= in_d;
      err_q <= err_d;
    end
  end

  // Outputs.
  always_comb begin
    stall    = (state_q != StIdle);
    // The print value stays visible until the core is released.
    out_vld  = (state_q == StOut) ||
               ((state_q == StRel) && (svc_q == SVC_W'(SVC_PRINT_INT)));
    out_data = out_vld ? arg_q : '0;
    in_req   = (state_q == StIn);
    wb_en    = (state_q == StWb);
    wb_data  = wb_en ? in_q : '0;
    halted   = (state_q == StHalt);
    svc_err  = err_q;
  end

endmodule
